regfile_port_scheduler: RTL and testbench

Sequences the shared 8×16 register file between `NUM_REQ` requesters (e.g. ALU writeback, load unit, debug port). It owns the `register_bus` master side, with one grant per cycle under round-robin arbitration and a valid/ready handshake. Read results return through a held response register. The block sits between the execution units and the `registers` instance and is the only driver of the register bus.

---
 rtl/regfile_port_scheduler_pkg.sv | 22 ++
 rtl/regfile_port_scheduler_if.sv | 33 +++
 rtl/regfile_port_scheduler_rr_arbiter.sv | 44 ++++
 rtl/regfile_port_scheduler.sv | 129 ++++++++++++
 tb/tb_regfile_port_scheduler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_port_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register file port scheduler slice.
//   REG_ADDR_W / REG_DATA_W / NUM_REGS : geometry of the 8x16 register file
//   DEFAULT_NUM_REQ                    : default requester count
//   rf_sched_state_t                   : scheduler FSM states
//   req_id_t                           : requester id at the default count
// ---------------------------------------------------------------------------
package regfile_pkg;
   localparam int REG_ADDR_W      = 3;
   localparam int REG_DATA_W      = 16;
   localparam int NUM_REGS        = 8;
   localparam int DEFAULT_NUM_REQ = 4;

   typedef enum logic [1:0] {
      IDLE,
      RD_ISSUE,
      RESP_HOLD
   } rf_sched_state_t;

   typedef logic [$clog2(DEFAULT_NUM_REQ)-1:0] req_id_t;
endpackage

// File: rtl/regfile_port_scheduler_if.sv
// ---------------------------------------------------------------------------
// register_bus
// Connection between the port scheduler (master) and the register file
// (slave). Reads are combinational in the register file; writes commit on
// the rising clock edge at the end of the cycle in which rf_we is high.
//   rf_we, rf_rd, rf_data_in : write side, driven by the master
//   rf_rs1, rf_rs2           : read addresses, driven by the master
//   rf_data_rs1, rf_data_rs2 : read data, driven by the slave
// ---------------------------------------------------------------------------
interface register_bus
   import regfile_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
);
   logic              rf_we;
   logic [ADDR_W-1:0] rf_rd;
   logic [DATA_W-1:0] rf_data_in;
   logic [ADDR_W-1:0] rf_rs1;
   logic [ADDR_W-1:0] rf_rs2;
   logic [DATA_W-1:0] rf_data_rs1;
   logic [DATA_W-1:0] rf_data_rs2;

   modport master (
      output rf_we, rf_rd, rf_data_in, rf_rs1, rf_rs2,
      input  rf_data_rs1, rf_data_rs2
   );

   modport slave (
      input  rf_we, rf_rd, rf_data_in, rf_rs1, rf_rs2,
      output rf_data_rs1, rf_data_rs2
   );
endinterface

// File: rtl/regfile_port_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches from index ptr upward
// (wrapping) for the first requester that is both requesting and eligible.
//   req      : request bits
//   mask     : eligibility bits
//   ptr      : index with highest priority this cycle
//   grant    : one-hot grant (all zero when nothing is eligible)
//   grant_id : index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter  int N  = DEFAULT_NUM_REQ,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_id
);

   logic found;
   int   idx;

   // Walk the requesters in priority order starting at ptr; the first
   // eligible one wins and later candidates are ignored via 'found'.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx] && mask[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_port_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_port_scheduler
// Sole master of the register bus. Grants one requester per cycle by
// round robin, issues writes one cycle after their handshake, and runs
// reads through RD_ISSUE into a held response register (RESP_HOLD).
//   clk, rst                        : clock, async active-high reset
//   req_valid / req_ready           : per-requester request handshake
//   req_we, req_rd, req_wdata       : write request fields
//   req_rs1, req_rs2                : read request source indices
//   resp_valid / resp_ready         : per-requester response handshake
//   resp_rs1_data, resp_rs2_data    : shared held read data
//   rf                              : register_bus master side
// The rf interface instance must be built with the same ADDR_W/DATA_W.
// ---------------------------------------------------------------------------
module regfile_port_scheduler
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = DEFAULT_NUM_REQ,
   parameter int DATA_W  = REG_DATA_W,
   parameter int ADDR_W  = REG_ADDR_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_rd,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_rs1,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_rs2,
   output logic [NUM_REQ-1:0]             resp_valid,
   input  logic [NUM_REQ-1:0]             resp_ready,
   output logic [DATA_W-1:0]              resp_rs1_data,
   output logic [DATA_W-1:0]              resp_rs2_data,
   register_bus.master                    rf
);

   localparam int IDW = $clog2(NUM_REQ);

   rf_sched_state_t  state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   resp_id;
   logic [NUM_REQ-1:0] elig_mask;
   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]   grant_id;
   logic             hs;
   logic             hs_we;
   logic [IDW-1:0]   ptr_next;

   // Eligibility follows the current state only: RD_ISSUE blocks everyone,
   // RESP_HOLD lets writes through but keeps new reads waiting until the
   // held response has been consumed.
   always_comb begin
      elig_mask = '0;
      case (state)
         IDLE:      elig_mask = '1;
         RESP_HOLD: elig_mask = req_we;
         default:   elig_mask = '0;
      endcase
   end

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req      (req_valid),
      .mask     (elig_mask),
      .ptr      (rr_ptr),
      .grant    (grant),
      .grant_id (grant_id)
   );

   // Grants are suppressed while reset is held so no requester sees a
   // handshake that the reset logic would then throw away.
   assign req_ready = rst ? '0 : grant;
   assign hs        = |grant;
   assign hs_we     = req_we[grant_id];
   assign ptr_next  = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   // Single state process: write issue register, read address register,
   // round-robin pointer and the read FSM with its held response. A write
   // is issued exactly in the cycle after its handshake, so grant order is
   // preserved on the bus and a following read sees the written value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         resp_id       <= '0;
         resp_valid    <= '0;
         resp_rs1_data <= '0;
         resp_rs2_data <= '0;
         rf.rf_we      <= 1'b0;
         rf.rf_rd      <= '0;
         rf.rf_data_in <= '0;
         rf.rf_rs1     <= '0;
         rf.rf_rs2     <= '0;
      end else begin
         rf.rf_we <= hs && hs_we;
         if (hs) begin
            rr_ptr <= ptr_next;
         end
         if (hs && hs_we) begin
            rf.rf_rd      <= req_rd[grant_id];
            rf.rf_data_in <= req_wdata[grant_id];
         end
         case (state)
            IDLE: begin
               if (hs && !hs_we) begin
                  rf.rf_rs1 <= req_rs1[grant_id];
                  rf.rf_rs2 <= req_rs2[grant_id];
                  resp_id   <= grant_id;
                  state     <= RD_ISSUE;
               end
            end
            RD_ISSUE: begin
               resp_rs1_data <= rf.rf_data_rs1;
               resp_rs2_data <= rf.rf_data_rs2;
               resp_valid    <= NUM_REQ'(1) << resp_id;
               state         <= RESP_HOLD;
            end
            RESP_HOLD: begin
               if (resp_ready[resp_id]) begin
                  resp_valid <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_port_scheduler
// Directed bench for regfile_port_scheduler with a behavioural 8x16
// register file on the slave side of register_bus.
// ---------------------------------------------------------------------------
module tb_regfile_port_scheduler;
   import regfile_pkg::*;

   logic              clk;
   logic              rst;
   logic [3:0]        req_valid;
   logic [3:0]        req_ready;
   logic [3:0]        req_we;
   logic [3:0][2:0]   req_rd;
   logic [3:0][15:0]  req_wdata;
   logic [3:0][2:0]   req_rs1;
   logic [3:0][2:0]   req_rs2;
   logic [3:0]        resp_valid;
   logic [3:0]        resp_ready;
   logic [15:0]       resp_rs1_data;
   logic [15:0]       resp_rs2_data;

   int checks = 0;
   int errors = 0;

   logic [15:0] regs [NUM_REGS] = '{default: '0};

   register_bus #(.ADDR_W(3), .DATA_W(16)) rbus ();

   regfile_port_scheduler #(.NUM_REQ(4), .DATA_W(16), .ADDR_W(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_rd        (req_rd),
      .req_wdata     (req_wdata),
      .req_rs1       (req_rs1),
      .req_rs2       (req_rs2),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_rs1_data (resp_rs1_data),
      .resp_rs2_data (resp_rs2_data),
      .rf            (rbus)
   );

   // Register file model: combinational reads, writes commit on the edge.
   assign rbus.rf_data_rs1 = regs[rbus.rf_rs1];
   assign rbus.rf_data_rs2 = regs[rbus.rf_rs2];
   always @(posedge clk) begin
      if (rbus.rf_we) regs[rbus.rf_rd] <= rbus.rf_data_in;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0; req_we = '0; req_rd = '0; req_wdata = '0;
      req_rs1 = '0; req_rs2 = '0; resp_ready = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      step(); step();
      req_valid = 4'b1111; req_we = 4'b1111;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rst_ready: got %b want 0000", req_ready); end
      checks++; if (resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rst_resp_valid: got %b want 0000", resp_valid); end
      checks++; if ({resp_rs1_data, resp_rs2_data} !== 32'h0) begin errors++; $display("[TB] FAIL rst_resp_data: got %h want 0", {resp_rs1_data, resp_rs2_data}); end
      checks++; if ({rbus.rf_we, rbus.rf_rd, rbus.rf_data_in, rbus.rf_rs1, rbus.rf_rs2} !== 26'h0) begin errors++; $display("[TB] FAIL rst_bus: got %h want 0", {rbus.rf_we, rbus.rf_rd, rbus.rf_data_in, rbus.rf_rs1, rbus.rf_rs2}); end
      clear_inputs();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++; if (rbus.rf_we !== 1'b0 || resp_valid !== 4'b0000 || req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL idle_cycle%0d: we=%b resp_valid=%b ready=%b want 0/0000/0000", k, rbus.rf_we, resp_valid, req_ready); end
      end
   endtask

   task automatic test_write_then_read();
      req_valid = 4'b0010; req_we[1] = 1'b1; req_rd[1] = 3'd3; req_wdata[1] = 16'hBEEF;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL wr_ready: got %b want 0010", req_ready); end
      step();
      checks++; if (rbus.rf_we !== 1'b1 || rbus.rf_rd !== 3'd3 || rbus.rf_data_in !== 16'hBEEF) begin errors++; $display("[TB] FAIL wr_issue: we=%b rd=%0d data=%h want 1/3/beef", rbus.rf_we, rbus.rf_rd, rbus.rf_data_in); end
      clear_inputs();
      req_valid = 4'b0100; req_rs1[2] = 3'd3; req_rs2[2] = 3'd0;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL rd_ready: got %b want 0100", req_ready); end
      step();
      req_valid = 4'b0001; req_we[0] = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rd_issue_mask: got %b want 0000", req_ready); end
      checks++; if (rbus.rf_we !== 1'b0 || rbus.rf_rs1 !== 3'd3 || rbus.rf_rs2 !== 3'd0 || resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rd_issue: we=%b rs1=%0d rs2=%0d resp_valid=%b want 0/3/0/0000", rbus.rf_we, rbus.rf_rs1, rbus.rf_rs2, resp_valid); end
      clear_inputs();
      step();
      checks++; if (resp_valid !== 4'b0100 || resp_rs1_data !== 16'hBEEF || resp_rs2_data !== 16'h0000) begin errors++; $display("[TB] FAIL rd_resp: valid=%b rs1=%h rs2=%h want 0100/beef/0000", resp_valid, resp_rs1_data, resp_rs2_data); end
      resp_ready = 4'b0100;
      step();
      resp_ready = '0;
      checks++; if (resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rd_consumed: got %b want 0000", resp_valid); end
   endtask

   task automatic test_back_to_back();
      int exp_g [6] = '{3, 0, 1, 2, 3, 0};
      logic [3:0] one;
      clear_inputs();
      req_valid = 4'b1111; req_we = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         req_rd[i] = 3'(i + 4);
         req_wdata[i] = 16'hA000 + 16'(i);
      end
      for (int k = 0; k < 6; k++) begin
         #1;
         one = 4'b0001 << exp_g[k];
         checks++; if (req_ready !== one) begin errors++; $display("[TB] FAIL b2b_grant%0d: got %b want %b", k, req_ready, one); end
         if (k > 0) begin
            checks++; if (rbus.rf_we !== 1'b1 || rbus.rf_rd !== 3'(exp_g[k-1] + 4)) begin errors++; $display("[TB] FAIL b2b_issue%0d: we=%b rd=%0d want 1/%0d", k, rbus.rf_we, rbus.rf_rd, exp_g[k-1] + 4); end
         end
         step();
      end
      clear_inputs();
      #1;
      checks++; if (rbus.rf_we !== 1'b1 || rbus.rf_rd !== 3'd4 || rbus.rf_data_in !== 16'hA000) begin errors++; $display("[TB] FAIL b2b_last: we=%b rd=%0d data=%h want 1/4/a000", rbus.rf_we, rbus.rf_rd, rbus.rf_data_in); end
      step();
      checks++; if (rbus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_we: got %b want 0", rbus.rf_we); end
   endtask

   task automatic test_resp_hold();
      clear_inputs();
      req_valid = 4'b0001; req_rs1[0] = 3'd3; req_rs2[0] = 3'd4;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL hold_rd_ready: got %b want 0001", req_ready); end
      step();
      clear_inputs();
      req_valid = 4'b1010;
      req_we[3] = 1'b1; req_rd[3] = 3'd5; req_wdata[3] = 16'h1234;
      req_rs1[1] = 3'd5; req_rs2[1] = 3'd3;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL hold_issue_mask: got %b want 0000", req_ready); end
      step();
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL hold_wr_grant: got %b want 1000", req_ready); end
      checks++; if (resp_valid !== 4'b0001 || resp_rs1_data !== 16'hBEEF || resp_rs2_data !== 16'hA000) begin errors++; $display("[TB] FAIL hold_resp: valid=%b rs1=%h rs2=%h want 0001/beef/a000", resp_valid, resp_rs1_data, resp_rs2_data); end
      step();
      req_valid = 4'b0010;
      #1;
      checks++; if (rbus.rf_we !== 1'b1 || rbus.rf_rd !== 3'd5 || rbus.rf_data_in !== 16'h1234) begin errors++; $display("[TB] FAIL hold_wr_issue: we=%b rd=%0d data=%h want 1/5/1234", rbus.rf_we, rbus.rf_rd, rbus.rf_data_in); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL hold_rd_masked%0d: got %b want 0000", k, req_ready); end
         checks++; if (resp_valid !== 4'b0001 || resp_rs1_data !== 16'hBEEF || resp_rs2_data !== 16'hA000) begin errors++; $display("[TB] FAIL hold_stable%0d: valid=%b rs1=%h rs2=%h want 0001/beef/a000", k, resp_valid, resp_rs1_data, resp_rs2_data); end
         if (k == 1) resp_ready = 4'b0010;
         if (k == 2) resp_ready = 4'b0001;
         #1;
         if (k == 2) begin
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL hold_same_cycle: got %b want 0000", req_ready); end
         end
         step();
      end
      resp_ready = '0;
      #1;
      checks++; if (resp_valid !== 4'b0000 || req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL hold_release: valid=%b ready=%b want 0000/0010", resp_valid, req_ready); end
      step();
      clear_inputs();
      step();
      checks++; if (resp_valid !== 4'b0010 || resp_rs1_data !== 16'h1234 || resp_rs2_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL hold_second_rd: valid=%b rs1=%h rs2=%h want 0010/1234/beef", resp_valid, resp_rs1_data, resp_rs2_data); end
      resp_ready = 4'b0010;
      step();
      resp_ready = '0;
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      req_valid = 4'b0100; req_rs1[2] = 3'd3; req_rs2[2] = 3'd3;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL mid_rd_ready: got %b want 0100", req_ready); end
      step();
      clear_inputs();
      rst = 1'b1;
      #1;
      checks++; if (resp_valid !== 4'b0000 || rbus.rf_rs1 !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst: valid=%b rs1=%0d want 0000/0", resp_valid, rbus.rf_rs1); end
      step();
      rst = 1'b0;
      step();
      checks++; if (resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL mid_after_rst: got %b want 0000", resp_valid); end
      req_valid = 4'b0001; req_we[0] = 1'b1; req_rd[0] = 3'd6; req_wdata[0] = 16'h5555;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL mid_idle_grant: got %b want 0001", req_ready); end
      step();
      clear_inputs();
      checks++; if (rbus.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL mid_wr_pending: got %b want 1", rbus.rf_we); end
      rst = 1'b1;
      #1;
      checks++; if (rbus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL mid_wr_drop: got %b want 0", rbus.rf_we); end
      step();
      rst = 1'b0;
      step();
      req_valid = 4'b0001; req_rs1[0] = 3'd3; req_rs2[0] = 3'd6;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL mid_rd2_ready: got %b want 0001", req_ready); end
      step();
      clear_inputs();
      step();
      checks++; if (resp_valid !== 4'b0001 || resp_rs1_data !== 16'hBEEF || resp_rs2_data !== 16'hA002) begin errors++; $display("[TB] FAIL mid_rd2_resp: valid=%b rs1=%h rs2=%h want 0001/beef/a002", resp_valid, resp_rs1_data, resp_rs2_data); end
      resp_ready = 4'b0001;
      step();
      resp_ready = '0;
   endtask

   task automatic test_same_addr();
      clear_inputs();
      req_valid = 4'b0010; req_we[1] = 1'b1; req_rd[1] = 3'd7; req_wdata[1] = 16'hFFFF;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL same_wr_ready: got %b want 0010", req_ready); end
      step();
      clear_inputs();
      req_valid = 4'b0100; req_rs1[2] = 3'd7; req_rs2[2] = 3'd7;
      #1;
      checks++; if (req_ready !== 4'b0100 || rbus.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL same_rd_ready: ready=%b we=%b want 0100/1", req_ready, rbus.rf_we); end
      step();
      clear_inputs();
      step();
      checks++; if (resp_valid !== 4'b0100 || resp_rs1_data !== 16'hFFFF || resp_rs2_data !== 16'hFFFF) begin errors++; $display("[TB] FAIL same_resp: valid=%b rs1=%h rs2=%h want 0100/ffff/ffff", resp_valid, resp_rs1_data, resp_rs2_data); end
      resp_ready = 4'b0100;
      step();
      resp_ready = '0;
   endtask

   initial begin
      test_reset();
      test_write_then_read();
      test_back_to_back();
      test_resp_hold();
      test_reset_mid();
      test_same_addr();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
